instr_encoder: RTL and testbench

Loader-side encoder for the multicycle processor. It accepts decoded instruction fields over a valid/ready handshake and packs each one into the 32-bit instruction word format that the decode stage consumes. It range-checks the immediate for the selected format and writes accepted words sequentially into instruction memory. It sits between the test/boot loader and the instruction memory write port.

---
 rtl/instr_encoder.sv | 193 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Loader-side instruction encoder: accepts decoded fields, packs them into the
// 32-bit decode word, range-checks the immediate and writes words sequentially.
module instr_encoder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_type,
    input  logic [4:0]  in_func,
    input  logic [4:0]  in_r1,
    input  logic [4:0]  in_r2,
    input  logic [4:0]  in_r3,
    input  logic [31:0] in_imm,
    input  logic        in_stop,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [8:0]  count,
    output logic        full,
    output logic        err,
    output logic        done
);

    localparam int unsigned CNT_W  = 9;
    localparam int unsigned WORD_W = 32;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [1:0] T_I = 2'b01;
    localparam logic [1:0] T_J = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        WRITE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state_q, state_nxt;

    // Field bundle captured at acceptance
    logic [1:0]        f_type;
    logic [4:0]        f_func, f_r1, f_r2, f_r3;
    logic [WORD_W-1:0] f_imm;
    logic              f_stop;

    logic [CNT_W-1:0]  count_q, count_nxt;
    logic              err_q, err_nxt;
    logic              done_q, done_nxt;
    logic              full_q, full_nxt;
    logic              in_ready_q, in_ready_nxt;
    logic              mem_we_q, mem_we_nxt;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_nxt;

    logic              accept_c;
    logic [WORD_W-1:0] word_c;
    logic              imm_ok_c;

    assign accept_c = (state_q == IDLE) && in_valid && in_ready_q;

    // Field capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_type <= '0;
            f_func <= '0;
            f_r1   <= '0;
            f_r2   <= '0;
            f_r3   <= '0;
            f_imm  <= '0;
            f_stop <= 1'b0;
        end else if (accept_c) begin
            f_type <= in_type;
            f_func <= in_func;
            f_r1   <= in_r1;
            f_r2   <= in_r2;
            f_r3   <= in_r3;
            f_imm  <= in_imm;
            f_stop <= in_stop;
        end
    end

    // Word packing and immediate range check; ranges mirror decode's re-extension
    always_comb begin
        word_c   = '0;
        imm_ok_c = 1'b0;
        case (f_type)
            T_I: begin
                word_c = {f_func, f_r1, f_r2, f_imm[13:0], f_type, f_stop};
                if (f_func == 5'd0) begin
                    imm_ok_c = (f_imm[31:14] == 18'd0);
                end else begin
                    imm_ok_c = (&f_imm[31:13]) || !(|f_imm[31:13]);
                end
            end
            T_J: begin
                word_c   = {f_func, f_imm[23:0], f_type, f_stop};
                imm_ok_c = (&f_imm[31:23]) || !(|f_imm[31:23]);
            end
            default: begin
                word_c   = {f_func, f_r1, f_r2, f_r3, f_imm[4:0], 4'b0000, f_type, f_stop};
                imm_ok_c = (f_imm[31:5] == 27'd0);
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state_q;
        count_nxt     = count_q;
        err_nxt       = err_q;
        done_nxt      = done_q;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = PACK;
                end
            end
            PACK: begin
                if (!imm_ok_c) begin
                    err_nxt   = 1'b1;
                    state_nxt = HALT;
                end else begin
                    state_nxt     = WRITE;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = BASE_ADDR + WORD_W'({count_q, 2'b00});
                    mem_wdata_nxt = word_c;
                end
            end
            WRITE: begin
                count_nxt = count_q + CNT_W'(1);
                done_nxt  = done_q | f_stop;
                state_nxt = (f_stop || (count_nxt == DEPTH_C)) ? HALT : IDLE;
            end
            default: begin
                state_nxt = HALT;
            end
        endcase

        // Restart wins over every transition; an in-flight write strobe has already been seen
        if (clear) begin
            state_nxt  = IDLE;
            count_nxt  = '0;
            err_nxt    = 1'b0;
            done_nxt   = 1'b0;
            mem_we_nxt = 1'b0;
        end

        full_nxt     = (count_nxt == DEPTH_C);
        in_ready_nxt = (state_nxt == IDLE) && !full_nxt && !err_nxt && !done_nxt;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_nxt;
            count_q     <= count_nxt;
            err_q       <= err_nxt;
            done_q      <= done_nxt;
            full_q      <= full_nxt;
            in_ready_q  <= in_ready_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = full_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed bundles push expected writes,
// a negedge monitor pops and compares every memory write strobe.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [4:0]  in_func, in_r1, in_r2, in_r3;
    logic [31:0] in_imm;
    logic        in_stop;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;
    logic        full;
    logic        err;
    logic        done;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_type  (in_type),
        .in_func  (in_func),
        .in_r1    (in_r1),
        .in_r2    (in_r2),
        .in_r3    (in_r3),
        .in_imm   (in_imm),
        .in_stop  (in_stop),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .count    (count),
        .full     (full),
        .err      (err),
        .done     (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %h data %h, none expected (t=%0t)",
                         mem_addr, mem_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", mem_addr, mon_e.addr);
                chk("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    // Offer a bundle for up to budget cycles; returns #1 after the accepting edge
    task automatic send(input logic [1:0] t, input logic [4:0] f, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c, input logic [31:0] imm,
                        input logic stp, input int budget, output bit acc);
        in_type  = t;
        in_func  = f;
        in_r1    = a;
        in_r2    = b;
        in_r3    = c;
        in_imm   = imm;
        in_stop  = stp;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            if (in_ready === 1'b1) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Full accepted write: returns #1 after the edge that ends WRITE
    task automatic wr(input logic [1:0] t, input logic [4:0] f, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] c, input logic [31:0] imm,
                      input logic stp, input logic [31:0] ea, input logic [31:0] ed);
        bit acc;
        exp_q.push_back('{addr: ea, data: ed});
        send(t, f, a, b, c, imm, stp, 8, acc);
        chk("accepted", 32'(acc), 32'd1);
        chk("pack_ready", 32'(in_ready), 32'd0);
        chk("pack_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        chk("write_we", 32'(mem_we), 32'd1);
        chk("write_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Immediate out of range: err two cycles after acceptance, no write, then restart
    task automatic err_case(input logic [1:0] t, input logic [4:0] f, input logic [31:0] imm);
        bit acc;
        send(t, f, 5'd1, 5'd2, 5'd3, imm, 1'b0, 8, acc);
        chk("err_accepted", 32'(acc), 32'd1);
        chk("err_pack_flag", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        chk("err_set", 32'(err), 32'd1);
        chk("err_no_we", 32'(mem_we), 32'd0);
        chk("err_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_count", 32'(count), 32'd0);
        do_clear();
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_clr_count", 32'(count), 32'd0);
        chk("err_clr_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit acc;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_type  = '0;
        in_func  = '0;
        in_r1    = '0;
        in_r2    = '0;
        in_r3    = '0;
        in_imm   = '0;
        in_stop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", {29'd0, full, err, done}, 32'd0);
        @(posedge clk);
        #1;

        // R, I zero-extended, I signed, then J with stop (also fills the 4th slot)
        wr(2'b00, 5'd3, 5'd1, 5'd2, 5'd3, 32'd5, 1'b0, 32'h0, 32'h18443280);
        chk("r_count", 32'(count), 32'd1);
        chk("r_ready", 32'(in_ready), 32'd1);
        wr(2'b01, 5'd0, 5'd4, 5'd5, 5'd9, 32'd100, 1'b0, 32'h4, 32'h010A0322);
        wr(2'b01, 5'd2, 5'd0, 5'd0, 5'd7, 32'hFFFFFFFF, 1'b0, 32'h8, 32'h1001FFFA);
        wr(2'b10, 5'd1, 5'd7, 5'd7, 5'd7, 32'hFFFFFFF8, 1'b1, 32'hC, 32'h0FFFFFC5);
        chk("stop_done", 32'(done), 32'd1);
        chk("stop_full", 32'(full), 32'd1);
        chk("stop_count", 32'(count), 32'd4);
        chk("stop_ready", 32'(in_ready), 32'd0);
        send(2'b00, 5'd1, 5'd1, 5'd1, 5'd1, 32'd1, 1'b0, 6, acc);
        chk("halt_no_accept", 32'(acc), 32'd0);
        do_clear();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_flags", {29'd0, full, err, done}, 32'd0);
        chk("clr_ready", 32'(in_ready), 32'd1);

        // Range edges that must be accepted
        wr(2'b01, 5'd5, 5'd0, 5'd0, 5'd0, 32'd8191, 1'b0, 32'h0, 32'h2800FFFA);
        wr(2'b01, 5'd5, 5'd0, 5'd0, 5'd0, 32'hFFFFE000, 1'b0, 32'h4, 32'h28010002);
        wr(2'b10, 5'd0, 5'd0, 5'd0, 5'd0, 32'h007FFFFF, 1'b0, 32'h8, 32'h03FFFFFC);
        chk("edge_count", 32'(count), 32'd3);
        chk("edge_full", 32'(full), 32'd0);
        do_clear();

        // Range violations
        err_case(2'b01, 5'd0, 32'hFFFFFFFF);
        err_case(2'b01, 5'd5, 32'd8192);
        err_case(2'b00, 5'd1, 32'd32);
        err_case(2'b10, 5'd1, 32'h00800000);

        // Fill to DEPTH; the fifth bundle must never be taken
        wr(2'b11, 5'd31, 5'd31, 5'd0, 5'd0, 32'd31, 1'b0, 32'h0, 32'hFFC00F86);
        wr(2'b00, 5'd0, 5'd0, 5'd31, 5'd31, 32'd0, 1'b0, 32'h4, 32'h003FF000);
        wr(2'b00, 5'd3, 5'd1, 5'd2, 5'd3, 32'd5, 1'b0, 32'h8, 32'h18443280);
        wr(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 32'd0, 1'b0, 32'hC, 32'h08864006);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_done", 32'(done), 32'd0);
        chk("full_ready", 32'(in_ready), 32'd0);
        send(2'b00, 5'd2, 5'd2, 5'd2, 5'd2, 32'd2, 1'b0, 8, acc);
        chk("full_no_accept", 32'(acc), 32'd0);
        do_clear();

        // clear during WRITE: the write completes, count restarts
        exp_q.push_back('{addr: 32'h0, data: 32'h18443280});
        send(2'b00, 5'd3, 5'd1, 5'd2, 5'd3, 32'd5, 1'b0, 8, acc);
        chk("cw_accepted", 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        chk("cw_we", 32'(mem_we), 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("cw_count", 32'(count), 32'd0);
        chk("cw_we_after", 32'(mem_we), 32'd0);
        chk("cw_ready", 32'(in_ready), 32'd1);

        // Reset during PACK: outputs return to reset values at once, no write follows
        wr(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 32'd0, 1'b0, 32'h0, 32'h08864006);
        send(2'b00, 5'd3, 5'd1, 5'd2, 5'd3, 32'd5, 1'b0, 8, acc);
        chk("rp_accepted", 32'(acc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rp_we", 32'(mem_we), 32'd0);
        chk("rp_count", 32'(count), 32'd0);
        chk("rp_addr", mem_addr, 32'h0);
        chk("rp_wdata", mem_wdata, 32'h0);
        chk("rp_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rp_ready_after", 32'(in_ready), 32'd1);
        chk("rp_count_after", 32'(count), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
